// File: rtl/sprite_mem_pkg.sv
// rtl/sprite_mem_pkg.sv - shared constants and helpers for the sprite memory arbiter
// Contents: bank selects, requester ids, sprite memory geometry, id to one-hot helper.
package sprite_mem_pkg;

    localparam logic MEM_SEL_FROG = 1'b0;
    localparam logic MEM_SEL_CAR  = 1'b1;

    localparam int REQ_FROG = 0;
    localparam int REQ_CAR  = 1;

    localparam int SPRITE_ADDR_W = 10;
    localparam int SPRITE_DATA_W = 9;

    // Requester id to the one-hot form used on o_rd_gnt / o_rd_valid.
    function automatic logic [1:0] req_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with registered last-grant pointer
// Ports: i_Clk, i_Reset (sync, active-high), req[1:0] requests, en pointer-update enable,
//        gnt[1:0] combinational one-hot grant.
module rr_arb2
    import sprite_mem_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // Id of the requester served last; reset to REQ_CAR so REQ_FROG wins first.
    logic last_id;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_id ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            last_id <= 1'(REQ_CAR);
        end else if (en && (|gnt)) begin
            last_id <= gnt[1];
        end
    end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// rtl/sprite_mem_arbiter.sv - shares the dual-bank sprite memory among two readers and one writer
// Ports: i_Clk, i_Reset (sync, active-high); read side i_rd_req/addr/sel, o_rd_gnt, o_rd_valid,
//        o_rd_data; write side i_wr_req/addr/data/sel, o_wr_gnt; memory side registered
//        o_mem_* command outputs and i_mem_rdata (registered read data).
module sprite_mem_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int ADDR_W       = SPRITE_ADDR_W,
    parameter int DATA_W       = SPRITE_DATA_W,
    parameter int WR_BURST_MAX = 4
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [1:0]        i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr0,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic              i_rd_sel0,
    input  logic              i_rd_sel1,
    output logic [1:0]        o_rd_gnt,
    output logic [1:0]        o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_sel,
    output logic              o_wr_gnt,
    output logic              o_mem_write_en,
    output logic              o_mem_read_en,
    output logic [ADDR_W-1:0] o_mem_write_addr,
    output logic [ADDR_W-1:0] o_mem_read_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_sel,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(WR_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(WR_BURST_MAX);

    logic             rd_pending;
    logic [1:0]       arb_gnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_any_gnt;
    logic             rd_gnt_id;

    // First tag stage: read issued to memory this cycle and who asked for it.
    logic             tag_vld;
    logic             tag_id;

    assign rd_pending = |i_rd_req;

    // Writes normally win; the burst cap only bites while some reader is waiting.
    assign o_wr_gnt = i_wr_req && ((burst_cnt < BURST_CAP) || !rd_pending);

    rr_arb2 u_rr_arb2 (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .req     (i_rd_req),
        .en      (!o_wr_gnt),
        .gnt     (arb_gnt)
    );

    assign o_rd_gnt   = o_wr_gnt ? 2'b00 : arb_gnt;
    assign rd_any_gnt = |o_rd_gnt;
    assign rd_gnt_id  = o_rd_gnt[REQ_CAR];
    assign o_rd_data  = i_mem_rdata;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            burst_cnt <= '0;
        end else if (!rd_pending || rd_any_gnt) begin
            burst_cnt <= '0;
        end else if (o_wr_gnt && (burst_cnt < BURST_CAP)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Memory command registers: only one accept per cycle, so one shared bank select.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_mem_write_en   <= 1'b0;
            o_mem_read_en    <= 1'b0;
            o_mem_write_addr <= '0;
            o_mem_read_addr  <= '0;
            o_mem_write_data <= '0;
            o_mem_sel        <= MEM_SEL_FROG;
        end else begin
            o_mem_write_en <= o_wr_gnt;
            o_mem_read_en  <= rd_any_gnt;
            if (o_wr_gnt) begin
                o_mem_write_addr <= i_wr_addr;
                o_mem_write_data <= i_wr_data;
                o_mem_sel        <= i_wr_sel;
            end else if (rd_any_gnt) begin
                o_mem_read_addr <= rd_gnt_id ? i_rd_addr1 : i_rd_addr0;
                o_mem_sel       <= rd_gnt_id ? i_rd_sel1 : i_rd_sel0;
            end
        end
    end

    // Tag pipeline: stage one tracks the read at the memory, stage two is o_rd_valid
    // itself, lined up with the memory's registered read data.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            tag_vld    <= 1'b0;
            tag_id     <= 1'b0;
            o_rd_valid <= 2'b00;
        end else begin
            tag_vld    <= rd_any_gnt;
            tag_id     <= rd_gnt_id;
            o_rd_valid <= tag_vld ? req_onehot(tag_id) : 2'b00;
        end
    end

endmodule
